// File: rtl/mem_wb_stage_if.sv
// Purpose: bundles the EX_MEM-side inputs and MEM/WB-side outputs of mem_wb_stage.
// Latency: none, wiring only.
// Backpressure: ou_stall travels back to the upstream (master) side.
// Ports (signals):
//   in_M[2:0]  {Branch, MemRead, MemWrite}   in_WB[1:0] write-back controls
//   in_add     branch target                 in_flag    ALU zero flag
//   in_res     ALU result / byte address     in_dat2    store data
//   in_mux     destination register
//   ou_pcsrc   take branch                   ou_target  branch target
//   ou_stall   freeze upstream               ou_rdata   registered load data
//   ou_res     registered ALU result         ou_mux     registered dest reg
//   ou_WB      registered WB controls (0 = bubble)
//   ou_misalign  registered misaligned-access flag (only with MEM_WB_MISALIGN_TRAP_EN)
// Optional macro: MEM_WB_MISALIGN_TRAP_EN adds ou_misalign.
interface mem_wb_stage_if;
  logic [2:0]  in_M;
  logic [1:0]  in_WB;
  logic [31:0] in_add;
  logic        in_flag;
  logic [31:0] in_res;
  logic [31:0] in_dat2;
  logic [4:0]  in_mux;

  logic        ou_pcsrc;
  logic [31:0] ou_target;
  logic        ou_stall;
  logic [31:0] ou_rdata;
  logic [31:0] ou_res;
  logic [4:0]  ou_mux;
  logic [1:0]  ou_WB;
`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic        ou_misalign;

  // The stage itself.
  modport slave (
    input  in_M, in_WB, in_add, in_flag, in_res, in_dat2, in_mux,
    output ou_pcsrc, ou_target, ou_stall, ou_rdata, ou_res, ou_mux, ou_WB,
    output ou_misalign
  );

  // The EX_MEM side driving the stage.
  modport master (
    output in_M, in_WB, in_add, in_flag, in_res, in_dat2, in_mux,
    input  ou_pcsrc, ou_target, ou_stall, ou_rdata, ou_res, ou_mux, ou_WB,
    input  ou_misalign
  );
`else
  // The stage itself.
  modport slave (
    input  in_M, in_WB, in_add, in_flag, in_res, in_dat2, in_mux,
    output ou_pcsrc, ou_target, ou_stall, ou_rdata, ou_res, ou_mux, ou_WB
  );

  // The EX_MEM side driving the stage.
  modport master (
    output in_M, in_WB, in_add, in_flag, in_res, in_dat2, in_mux,
    input  ou_pcsrc, ou_target, ou_stall, ou_rdata, ou_res, ou_mux, ou_WB
  );
`endif
endinterface

// File: rtl/mem_wb_stage.sv
// Purpose: MIPS MEM stage merged with the MEM/WB buffer: data memory, branch resolve, WB registers.
// Latency: loads/stores complete after MEM_LAT cycles; non-memory ops register in 1 cycle.
// Backpressure: ou_stall (combinational) freezes upstream while a multi-cycle access is pending.
// Ports: clk, rst (synchronous, active-high) plus bus (mem_wb_stage_if.slave),
//   see mem_wb_stage_if.sv for the per-signal summary.
// Optional macro: MEM_WB_MISALIGN_TRAP_EN traps accesses with in_res[1:0] != 0
//   (write suppressed, ou_rdata/ou_WB zeroed, ou_misalign set); without it
//   the low address bits are ignored and the access is silently word-aligned.
module mem_wb_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1     // legal range 1..15
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam bit       MULTI    = (MEM_LAT > 1);
  // Counter preload when entering WAIT; the IDLE cycle is the first of the
  // MEM_LAT cycles and the cnt==0 WAIT cycle is the last.
  localparam logic [3:0] CNT_INIT = MULTI ? 4'(MEM_LAT - 2) : 4'd0;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic [31:0] res_q;
  logic [4:0]  mux_q;
  logic [1:0]  wb_q;

  logic              access;
  logic              mem_read;
  logic              mem_write;
  logic              complete;
  logic              stall;
  logic              trap;
  logic [ADDR_W-1:0] addr;

  assign mem_read  = bus.in_M[1];
  assign mem_write = bus.in_M[0];
  assign access    = mem_read | mem_write;
  // Upper address bits are dropped, so the memory wraps modulo DEPTH.
  assign addr      = bus.in_res[ADDR_W+1:2];

`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap            = access & (bus.in_res[1:0] != 2'b00);
  assign bus.ou_misalign = misalign_q;
`else
  assign trap = 1'b0;
`endif

  // Next-state / stall / completion decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && MULTI) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          stall   = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          stall = 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      res_q   <= 32'd0;
      mux_q   <= 5'd0;
      wb_q    <= 2'd0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete) begin
        // Non-blocking read of mem gives the pre-write word on a combined rd/wr.
        rdata_q <= (mem_read && !trap) ? mem[addr] : 32'd0;
        res_q   <= bus.in_res;
        mux_q   <= bus.in_mux;
        wb_q    <= trap ? 2'd0 : bus.in_WB;
`ifdef MEM_WB_MISALIGN_TRAP_EN
        misalign_q <= trap;
`endif
      end else begin
        // Stalled edge: hold data, issue a bubble to write-back.
        wb_q <= 2'd0;
      end
    end
  end

  // Data memory is not reset; a reset edge also aborts any pending write.
  always_ff @(posedge clk) begin
    if (!rst && complete && mem_write && !trap) begin
      mem[addr] <= bus.in_dat2;
    end
  end

  assign bus.ou_pcsrc  = bus.in_M[2] & bus.in_flag;
  assign bus.ou_target = bus.in_add;
  assign bus.ou_stall  = stall;
  assign bus.ou_rdata  = rdata_q;
  assign bus.ou_res    = res_q;
  assign bus.ou_mux    = mux_q;
  assign bus.ou_WB     = wb_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Inputs change just after the falling edge; registered outputs are sampled 1ns after the rising edge.
module tb_mem_wb_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_wb_stage_if bus1();
  mem_wb_stage_if bus3();

  mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv1(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] res,
                      input logic [31:0] dat, input logic [4:0] mux);
    bus1.in_M = m; bus1.in_WB = wb; bus1.in_res = res; bus1.in_dat2 = dat;
    bus1.in_mux = mux; bus1.in_flag = 1'b0; bus1.in_add = 32'd0;
  endtask

  task automatic drv3(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] res,
                      input logic [31:0] dat, input logic [4:0] mux);
    bus3.in_M = m; bus3.in_WB = wb; bus3.in_res = res; bus3.in_dat2 = dat;
    bus3.in_mux = mux; bus3.in_flag = 1'b0; bus3.in_add = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv1(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
    drv3(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus1.ou_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata1 got %h want 0", bus1.ou_rdata); end
    n_checks++; if (bus1.ou_WB !== 2'd0) begin n_errors++; $display("FAIL reset_wb1 got %h want 0", bus1.ou_WB); end
    n_checks++; if (bus3.ou_res !== 32'd0) begin n_errors++; $display("FAIL reset_res3 got %h want 0", bus3.ou_res); end
    n_checks++; if (bus3.ou_mux !== 5'd0) begin n_errors++; $display("FAIL reset_mux3 got %h want 0", bus3.ou_mux); end
    n_checks++; if (bus3.ou_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall3 got %b want 0", bus3.ou_stall); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lat1_store_load();
    @(negedge clk);
    drv1(3'b001, 2'b11, 32'h10, 32'hDEADBEEF, 5'd5);
    #1;
    n_checks++; if (bus1.ou_stall !== 1'b0) begin n_errors++; $display("FAIL lat1_sw_stall got %b want 0", bus1.ou_stall); end
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_WB !== 2'b11) begin n_errors++; $display("FAIL lat1_sw_wb got %h want 3", bus1.ou_WB); end
    n_checks++; if (bus1.ou_rdata !== 32'd0) begin n_errors++; $display("FAIL lat1_sw_rdata got %h want 0", bus1.ou_rdata); end
    n_checks++; if (bus1.ou_mux !== 5'd5) begin n_errors++; $display("FAIL lat1_sw_mux got %h want 5", bus1.ou_mux); end
    @(negedge clk);
    drv1(3'b010, 2'b10, 32'h10, 32'd0, 5'd7);
    #1;
    n_checks++; if (bus1.ou_stall !== 1'b0) begin n_errors++; $display("FAIL lat1_lw_stall got %b want 0", bus1.ou_stall); end
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lat1_lw_rdata got %h want deadbeef", bus1.ou_rdata); end
    n_checks++; if (bus1.ou_WB !== 2'b10) begin n_errors++; $display("FAIL lat1_lw_wb got %h want 2", bus1.ou_WB); end
    n_checks++; if (bus1.ou_mux !== 5'd7) begin n_errors++; $display("FAIL lat1_lw_mux got %h want 7", bus1.ou_mux); end
    n_checks++; if (bus1.ou_res !== 32'h10) begin n_errors++; $display("FAIL lat1_lw_res got %h want 10", bus1.ou_res); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drv1(3'b001, 2'b01, 32'h400, 32'h1, 5'd1);
    @(posedge clk);
    @(negedge clk);
    drv1(3'b010, 2'b01, 32'h0, 32'd0, 5'd2);
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_rdata !== 32'h1) begin n_errors++; $display("FAIL wrap_rdata got %h want 1", bus1.ou_rdata); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    drv1(3'b100, 2'b00, 32'd0, 32'd0, 5'd0);
    bus1.in_flag = 1'b1;
    bus1.in_add  = 32'h40;
    #1;
    n_checks++; if (bus1.ou_pcsrc !== 1'b1) begin n_errors++; $display("FAIL branch_taken got %b want 1", bus1.ou_pcsrc); end
    n_checks++; if (bus1.ou_target !== 32'h40) begin n_errors++; $display("FAIL branch_target got %h want 40", bus1.ou_target); end
    n_checks++; if (bus1.ou_stall !== 1'b0) begin n_errors++; $display("FAIL branch_stall got %b want 0", bus1.ou_stall); end
    bus1.in_flag = 1'b0;
    #1;
    n_checks++; if (bus1.ou_pcsrc !== 1'b0) begin n_errors++; $display("FAIL branch_not_taken got %b want 0", bus1.ou_pcsrc); end
    bus1.in_M = 3'b000;
  endtask

  task automatic test_lat3_load();
    @(negedge clk);
    drv3(3'b001, 2'b00, 32'h30, 32'h1234, 5'd2);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus3.ou_mux !== 5'd2) begin n_errors++; $display("FAIL lat3_sw_mux got %h want 2", bus3.ou_mux); end
    @(negedge clk);
    drv3(3'b010, 2'b11, 32'h30, 32'd0, 5'd9);
    #1;
    n_checks++; if (bus3.ou_stall !== 1'b1) begin n_errors++; $display("FAIL lat3_stall_c1 got %b want 1", bus3.ou_stall); end
    @(posedge clk); #1;
    n_checks++; if (bus3.ou_WB !== 2'b00) begin n_errors++; $display("FAIL lat3_bubble_e1 got %h want 0", bus3.ou_WB); end
    n_checks++; if (bus3.ou_mux !== 5'd2) begin n_errors++; $display("FAIL lat3_hold_mux got %h want 2", bus3.ou_mux); end
    @(negedge clk); #1;
    n_checks++; if (bus3.ou_stall !== 1'b1) begin n_errors++; $display("FAIL lat3_stall_c2 got %b want 1", bus3.ou_stall); end
    @(posedge clk); #1;
    n_checks++; if (bus3.ou_WB !== 2'b00) begin n_errors++; $display("FAIL lat3_bubble_e2 got %h want 0", bus3.ou_WB); end
    @(negedge clk); #1;
    n_checks++; if (bus3.ou_stall !== 1'b0) begin n_errors++; $display("FAIL lat3_stall_c3 got %b want 0", bus3.ou_stall); end
    @(posedge clk); #1;
    n_checks++; if (bus3.ou_WB !== 2'b11) begin n_errors++; $display("FAIL lat3_wb_e3 got %h want 3", bus3.ou_WB); end
    n_checks++; if (bus3.ou_rdata !== 32'h1234) begin n_errors++; $display("FAIL lat3_rdata got %h want 1234", bus3.ou_rdata); end
    n_checks++; if (bus3.ou_mux !== 5'd9) begin n_errors++; $display("FAIL lat3_mux got %h want 9", bus3.ou_mux); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drv3(3'b001, 2'b00, 32'h20, 32'hAAAA0001, 5'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drv3(3'b001, 2'b01, 32'h20, 32'hBBBB0002, 5'd3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus3.ou_res !== 32'd0) begin n_errors++; $display("FAIL rstwait_res got %h want 0", bus3.ou_res); end
    n_checks++; if (bus3.ou_mux !== 5'd0) begin n_errors++; $display("FAIL rstwait_mux got %h want 0", bus3.ou_mux); end
    n_checks++; if (bus3.ou_WB !== 2'd0) begin n_errors++; $display("FAIL rstwait_wb got %h want 0", bus3.ou_WB); end
    n_checks++; if (bus3.ou_rdata !== 32'd0) begin n_errors++; $display("FAIL rstwait_rdata got %h want 0", bus3.ou_rdata); end
    @(negedge clk);
    rst = 1'b0;
    drv3(3'b010, 2'b10, 32'h20, 32'd0, 5'd4);
    #1;
    // Only IDLE stalls on a fresh access; a leftover WAIT with cnt==0 would not.
    n_checks++; if (bus3.ou_stall !== 1'b1) begin n_errors++; $display("FAIL rstwait_idle_stall got %b want 1", bus3.ou_stall); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus3.ou_rdata !== 32'hAAAA0001) begin n_errors++; $display("FAIL rstwait_old_data got %h want aaaa0001", bus3.ou_rdata); end
    n_checks++; if (bus3.ou_WB !== 2'b10) begin n_errors++; $display("FAIL rstwait_lw_wb got %h want 2", bus3.ou_WB); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drv3(3'b000, 2'b10, 32'h55, 32'd0, 5'd6);
    #1;
    n_checks++; if (bus3.ou_stall !== 1'b0) begin n_errors++; $display("FAIL b2b_alu_stall got %b want 0", bus3.ou_stall); end
    @(posedge clk); #1;
    n_checks++; if (bus3.ou_res !== 32'h55) begin n_errors++; $display("FAIL b2b_alu_res got %h want 55", bus3.ou_res); end
    n_checks++; if (bus3.ou_rdata !== 32'd0) begin n_errors++; $display("FAIL b2b_alu_rdata got %h want 0", bus3.ou_rdata); end
    @(negedge clk);
    drv3(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
    drv1(3'b010, 2'b01, 32'h10, 32'd0, 5'd1);
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_lw0 got %h want deadbeef", bus1.ou_rdata); end
    @(negedge clk);
    drv1(3'b010, 2'b01, 32'h0, 32'd0, 5'd2);
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_rdata !== 32'h1) begin n_errors++; $display("FAIL b2b_lw1 got %h want 1", bus1.ou_rdata); end
    @(negedge clk);
    drv1(3'b011, 2'b11, 32'h10, 32'hCAFEF00D, 5'd3);
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_rw_old got %h want deadbeef", bus1.ou_rdata); end
    @(negedge clk);
    drv1(3'b010, 2'b01, 32'h10, 32'd0, 5'd4);
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_rdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL b2b_rw_new got %h want cafef00d", bus1.ou_rdata); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drv1(3'b010, 2'b01, 32'h13, 32'd0, 5'd5);
    @(posedge clk); #1;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    n_checks++; if (bus1.ou_misalign !== 1'b1) begin n_errors++; $display("FAIL mis_flag got %b want 1", bus1.ou_misalign); end
    n_checks++; if (bus1.ou_WB !== 2'b00) begin n_errors++; $display("FAIL mis_wb got %h want 0", bus1.ou_WB); end
    n_checks++; if (bus1.ou_rdata !== 32'd0) begin n_errors++; $display("FAIL mis_rdata got %h want 0", bus1.ou_rdata); end
    @(negedge clk);
    drv1(3'b010, 2'b01, 32'h10, 32'd0, 5'd6);
    @(posedge clk); #1;
    n_checks++; if (bus1.ou_misalign !== 1'b0) begin n_errors++; $display("FAIL mis_clear got %b want 0", bus1.ou_misalign); end
    n_checks++; if (bus1.ou_rdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL mis_aligned_rdata got %h want cafef00d", bus1.ou_rdata); end
`else
    n_checks++; if (bus1.ou_rdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL unaligned_rdata got %h want cafef00d", bus1.ou_rdata); end
    n_checks++; if (bus1.ou_WB !== 2'b01) begin n_errors++; $display("FAIL unaligned_wb got %h want 1", bus1.ou_WB); end
`endif
    @(negedge clk);
    drv1(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_lat1_store_load();
    test_wrap();
    test_branch();
    test_lat3_load();
    test_reset_in_wait();
    test_back_to_back();
    test_misalign();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
